// File: rtl/serial_rx_stage.sv
// serial_rx_stage: 8-channel serial frame receiver; define SERIAL_RX_GRAY2BIN_EN to store Gray-decoded bits
module serial_rx_stage (
   input  logic         clk_out16x,
   input  logic         rst_n,
   input  logic [7:0]   data_in,
   input  logic [7:0]   data_vld,
   output logic [127:0] frame_data,
   output logic [7:0]   frame_ch,
   output logic [15:0]  frame_len,
   output logic         frame_valid,
   output logic         frame_err,
   output logic         sel_err,
   output logic         busy
);
   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
   state_t       r_state;
   state_t       w_state_nxt;
   logic [7:0]   r_ch;
   logic [15:0]  r_cnt;
   logic [127:0] r_cap;
   logic         r_err;
   logic         w_any;
   logic         w_onehot;
   logic         w_multi;
   logic         w_start;
   logic         w_ch_vld;
   logic         w_other;
   logic         w_end;
   logic         w_in_range;
   logic         w_start_bit;
   logic         w_bit_rx;
   logic         w_bit_st;
   logic         w_fv_nxt;
   logic         w_se_nxt;
   logic         w_fe_nxt;
   logic [6:0]   w_pos;
   assign w_any       = |data_vld;
   assign w_onehot    = w_any && ((data_vld & (data_vld - 8'd1)) == 8'd0);
   assign w_multi     = w_any && !w_onehot;
   assign w_start     = (r_state == IDLE) && w_onehot;
   assign w_ch_vld    = |(data_vld & r_ch);
   assign w_other     = |(data_vld & ~r_ch);
   assign w_end       = (r_state == RECV) && !w_ch_vld;
   assign w_in_range  = r_cnt < 16'd128;
   assign w_pos       = ~r_cnt[6:0];
   assign w_start_bit = |(data_in & data_vld);
   assign w_bit_rx    = |(data_in & r_ch);
`ifdef SERIAL_RX_GRAY2BIN_EN
   logic r_prev;
   assign w_bit_st = w_bit_rx ^ r_prev;
   // Last decoded bit of the frame, the reference for decoding the next Gray bit
   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b0;
      else if (w_start) r_prev <= w_start_bit;
      else if (r_state == RECV && w_ch_vld && w_in_range) r_prev <= w_bit_st;
   end
`else
   assign w_bit_st = w_bit_rx;
`endif
   // State register
   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end
   // Start on a one-hot valid in IDLE, stay in RECV while the latched channel stays valid
   always_comb begin
      w_state_nxt = (r_state == IDLE) ? (w_onehot ? RECV : IDLE) : (w_ch_vld ? RECV : IDLE);
   end
   // Busy flag and next values of the pulsed and frame-qualified status outputs
   always_comb begin
      busy     = (r_state == RECV);
      w_fv_nxt = w_end;
      w_se_nxt = (r_state == IDLE) && w_multi;
      w_fe_nxt = r_err | w_other;
   end
   // Capture path: first bit lands at [127], bits past 128 only count and flag an error
   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) begin
         r_ch  <= 8'd0;
         r_cnt <= 16'd0;
         r_cap <= 128'd0;
         r_err <= 1'b0;
      end else if (w_start) begin
         r_ch  <= data_vld;
         r_cnt <= 16'd1;
         r_cap <= {w_start_bit, 127'd0};
         r_err <= 1'b0;
      end else if (r_state == RECV && w_ch_vld) begin
         if (w_in_range) r_cap[w_pos] <= w_bit_st;
         r_cnt <= r_cnt + {15'd0, r_cnt != 16'hFFFF};
         r_err <= r_err | w_other | !w_in_range;
      end
   end
   // Output registers: frame results load when the channel drops and then hold
   always_ff @(posedge clk_out16x or negedge rst_n) begin
      if (!rst_n) begin
         frame_data  <= 128'd0;
         frame_ch    <= 8'd0;
         frame_len   <= 16'd0;
         frame_err   <= 1'b0;
         frame_valid <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         frame_valid <= w_fv_nxt;
         sel_err     <= w_se_nxt;
         if (w_end) begin
            frame_data <= r_cap;
            frame_ch   <= r_ch;
            frame_len  <= r_cnt;
            frame_err  <= w_fe_nxt;
         end
      end
   end
endmodule

// File: tb/tb_serial_rx_stage.sv
// tb_serial_rx_stage: directed table-driven bench for serial_rx_stage
module tb_serial_rx_stage;
   logic         clk_out16x = 1'b0;
   logic         rst_n;
   logic [7:0]   data_in;
   logic [7:0]   data_vld;
   logic [127:0] frame_data;
   logic [7:0]   frame_ch;
   logic [15:0]  frame_len;
   logic         frame_valid;
   logic         frame_err;
   logic         sel_err;
   logic         busy;
   int           n_cmp = 0;
   int           n_bad = 0;

   typedef struct {
      int           ch;
      int           n;
      logic [127:0] w;
      logic [127:0] d;
      logic [7:0]   fch;
      logic [15:0]  len;
      logic         err;
   } vec_t;
   vec_t v[6];

   serial_rx_stage dut (
      .clk_out16x (clk_out16x),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_vld   (data_vld),
      .frame_data (frame_data),
      .frame_ch   (frame_ch),
      .frame_len  (frame_len),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .sel_err    (sel_err),
      .busy       (busy)
   );

   always #5 clk_out16x = ~clk_out16x;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

`ifdef SERIAL_RX_GRAY2BIN_EN
   function automatic logic [127:0] g2b(input logic [127:0] w, input int n);
      logic p;
      p = 1'b0;
      g2b = '0;
      for (int i = 0; i < n && i < 128; i++) begin
         p = p ^ w[127-i];
         g2b[127-i] = p;
      end
   endfunction
`endif

   task automatic check_zero(input string nm);
      chk({nm, "_data"}, frame_data, 128'd0);
      chk({nm, "_ch"}, 128'(frame_ch), 128'd0);
      chk({nm, "_len"}, 128'(frame_len), 128'd0);
      chk({nm, "_fv"}, 128'(frame_valid), 128'd0);
      chk({nm, "_ferr"}, 128'(frame_err), 128'd0);
      chk({nm, "_selerr"}, 128'(sel_err), 128'd0);
      chk({nm, "_busy"}, 128'(busy), 128'd0);
   endtask

   // Called at a negedge; returns at the negedge where frame_valid should be high
   task automatic send(input int ch, input logic [127:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         data_vld = 8'h01 << ch;
         data_in  = ((i < 128) ? w[127-i] : 1'b1) ? data_vld : 8'h00;
         @(negedge clk_out16x);
         if (i == 0) begin
            chk("busy_after_start", 128'(busy), 128'd1);
            chk("fv_single_pulse", 128'(frame_valid), 128'd0);
         end
      end
      data_vld = 8'h00;
      data_in  = 8'h00;
      @(negedge clk_out16x);
   endtask

   task automatic check_frame(input string nm, input logic [127:0] d, input logic [7:0] fch,
                              input logic [15:0] len, input logic err);
      chk({nm, "_fv"}, 128'(frame_valid), 128'd1);
      chk({nm, "_data"}, frame_data, d);
      chk({nm, "_ch"}, 128'(frame_ch), 128'(fch));
      chk({nm, "_len"}, 128'(frame_len), 128'(len));
      chk({nm, "_err"}, 128'(frame_err), 128'(err));
   endtask

   initial begin
      logic [127:0] e;
      v[0] = '{2, 128, 128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1D2C3,
               128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1D2C3, 8'h04, 16'd128, 1'b0};
      v[1] = '{7, 4, {4'b1011, 124'd0}, {4'hB, 124'd0}, 8'h80, 16'd4, 1'b0};
      v[2] = '{0, 8, {8'hA5, 120'd0}, {8'hA5, 120'd0}, 8'h01, 16'd8, 1'b0};
      v[3] = '{0, 8, {8'h3C, 120'd0}, {8'h3C, 120'd0}, 8'h01, 16'd8, 1'b0};
      v[4] = '{0, 4, {4'b1101, 124'd0}, {4'b1101, 124'd0}, 8'h01, 16'd4, 1'b0};
      v[5] = '{1, 130, 128'hFFFF0000_AAAA5555_12345678_9ABCDEF0,
               128'hFFFF0000_AAAA5555_12345678_9ABCDEF0, 8'h02, 16'd130, 1'b1};
`ifdef SERIAL_RX_GRAY2BIN_EN
      for (int i = 0; i < 6; i++) v[i].d = g2b(v[i].w, v[i].n);
      chk("gray_1101", v[4].d, {4'b1001, 124'd0});
`endif
      rst_n    = 1'b0;
      data_vld = 8'h00;
      data_in  = 8'h00;
      repeat (3) @(negedge clk_out16x);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk_out16x);
      chk("idle_busy", 128'(busy), 128'd0);
      chk("idle_fv", 128'(frame_valid), 128'd0);

      for (int i = 0; i < 6; i++) begin
         send(v[i].ch, v[i].w, v[i].n);
         check_frame($sformatf("vec%0d", i), v[i].d, v[i].fch, v[i].len, v[i].err);
      end

      data_vld = 8'h03;
      data_in  = 8'h03;
      @(negedge clk_out16x);
      chk("selerr_pulse", 128'(sel_err), 128'd1);
      chk("selerr_busy", 128'(busy), 128'd0);
      chk("selerr_fv", 128'(frame_valid), 128'd0);
      data_vld = 8'h00;
      data_in  = 8'h00;
      @(negedge clk_out16x);
      chk("selerr_end", 128'(sel_err), 128'd0);
      chk("selerr_nobusy", 128'(busy), 128'd0);
      chk("hold_len", 128'(frame_len), 128'd130);
      chk("hold_err", 128'(frame_err), 128'd1);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'h5A;
         data_vld = 8'h08 | ((i == 2) ? 8'h01 : 8'h00);
         data_in  = b[7-i] ? 8'h08 : 8'h00;
         @(negedge clk_out16x);
      end
      data_vld = 8'h00;
      data_in  = 8'h00;
      @(negedge clk_out16x);
`ifdef SERIAL_RX_GRAY2BIN_EN
      e = g2b({8'h5A, 120'd0}, 8);
`else
      e = {8'h5A, 120'd0};
`endif
      check_frame("otherch", e, 8'h08, 16'd8, 1'b1);

      for (int i = 0; i < 50; i++) begin
         data_vld = 8'h10;
         data_in  = i[0] ? 8'h10 : 8'h00;
         @(negedge clk_out16x);
      end
      chk("mid_busy", 128'(busy), 128'd1);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk_out16x);
      data_vld = 8'h00;
      data_in  = 8'h00;
      @(negedge clk_out16x);
      check_zero("midrst_hold");
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk_out16x);
         chk("postrst_fv", 128'(frame_valid), 128'd0);
      end
      send(4, {16'hC3A5, 112'd0}, 16);
`ifdef SERIAL_RX_GRAY2BIN_EN
      e = g2b({16'hC3A5, 112'd0}, 16);
`else
      e = {16'hC3A5, 112'd0};
`endif
      check_frame("postrst", e, 8'h10, 16'd16, 1'b0);
      @(negedge clk_out16x);
      chk("postrst_pulse_end", 128'(frame_valid), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_rx_stage.md
SERIAL_RX_STAGE -- requirements
Module: serial_rx_stage

Interface
REQ-001 clk_out16x  input  1  serial bit clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 data_in  input  8  serial data; bit k = channel k+1, MSB-first.
REQ-004 data_vld  input  8  per-channel valid; bit k = channel k+1; nominally one-hot.
REQ-005 frame_data  output  128  received frame, left-aligned; first received bit at [127], unfilled bits 0.
REQ-006 frame_ch  output  8  one-hot channel of the delivered frame.
REQ-007 frame_len  output  16  number of valid-high cycles in the delivered frame, saturating at 16'hFFFF.
REQ-008 frame_valid  output  1  single-cycle pulse; frame_data/frame_ch/frame_len/frame_err are new this cycle.
REQ-009 frame_err  output  1  error flag qualified by frame_valid.
REQ-010 sel_err  output  1  single-cycle pulse: start rejected because more than one data_vld bit was high in IDLE.
REQ-011 busy  output  1  high while in RECV.

Function
REQ-012 Two states, IDLE and RECV; all outputs registered.
REQ-013 IDLE, data_vld exactly one-hot: latch channel, store data_in of that channel as bit 0 of the frame, set count=1, go to RECV.
REQ-014 IDLE, data_vld with two or more bits high: pulse sel_err, capture nothing, stay in IDLE.
REQ-015 IDLE, data_vld==0: stay in IDLE, outputs hold.
REQ-016 RECV, data_vld[ch]=1: store data_in[ch] at frame bit position 127-count when count<128; increment count, saturating at 16'hFFFF.
REQ-017 RECV, data_vld[ch]=0: at this edge load frame_data, frame_ch, frame_len=count, frame_err; pulse frame_valid for one cycle; return to IDLE.
REQ-018 Latency: frame_valid rises 1 cycle after the last valid-high bit cycle. The same-edge data_vld sample is ignored for start detection.
REQ-019 A new frame can start on the cycle immediately after frame_valid, giving a minimum 1-cycle valid-low gap.
REQ-020 frame_err=1 if count exceeded 128 (extra bits are discarded).
REQ-021 frame_err=1 if any data_vld bit other than the latched channel was high during RECV.
REQ-022 frame_data, frame_ch, frame_len and frame_err hold until the next frame_valid.
REQ-023 The internal capture register is cleared on entry to RECV, so unfilled bits of a short frame read 0.

Reset
REQ-024 rst_n low: state=IDLE; count=0; the capture register, frame_data, frame_ch, frame_len, frame_valid, frame_err, sel_err and busy are all 0.
REQ-025 Reset mid-RECV discards the partial frame; no frame_valid is produced for it.
REQ-026 After rst_n deassertion, the first edge sampling a one-hot data_vld starts a frame normally.

Configuration
REQ-027 Macro SERIAL_RX_GRAY2BIN_EN defined: each stored bit is b = g XOR (previously stored decoded bit of this frame); the first bit is stored as received. This applies to the first 128 bits only, so frame_data holds the binary equivalent of the received Gray word, with no added latency.
REQ-028 Macro undefined: raw received bits are stored; no XOR logic is present.

Verification
REQ-029 Reset, then ch3 valid for 128 cycles carrying 128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1D2C3 MSB-first -> frame_valid 1 cycle after the last bit; frame_data equals that word; frame_ch=8'h04; frame_len=128; frame_err=0.
REQ-030 ch8 valid for 4 cycles with bits 1,0,1,1 -> frame_data=128'hB000...0; frame_ch=8'h80; frame_len=4.
REQ-031 Two ch1 frames of 8 bits (8'hA5, 8'h3C) separated by one valid-low cycle -> two frame_valid pulses; frame_data[127:120]=8'hA5 then 8'h3C.
REQ-032 data_vld=8'h03 in IDLE -> sel_err pulse, busy stays 0, no frame_valid; ch2 valid for 130 cycles -> frame_len=130, frame_err=1, frame_data holds the first 128 bits.
REQ-033 rst_n asserted at bit 50 of a ch5 frame -> no frame_valid, all outputs 0; the next 16-bit frame is received correctly.
REQ-034 With SERIAL_RX_GRAY2BIN_EN defined, send 4-bit Gray 4'b1101 on ch1 -> frame_data[127:124]=4'b1001.
